encode_token: RTL and testbench

ENCODE_TOKEN -- requirements
Module: encode_token

---
 rtl/encode_token.sv | 139 +++++++++++++
 tb/tb_encode_token.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_token.sv
// encode_token: LZS token encoder. Turns literal / match / end-of-stream
// tokens into right-aligned code beats (MSB transmitted first). A match
// emits an offset beat, then a length code, then zero or more 4-bit
// extension beats for long lengths.
module encode_token #(
  parameter int OFF_W = 11,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_type,
  input  logic [7:0]       tok_lit,
  input  logic [OFF_W-1:0] tok_off,
  input  logic [LEN_W-1:0] tok_len,
  output logic [12:0]      cnt_output,
  output logic [3:0]       cnt_len,
  output logic             cnt_output_enable,
  output logic             cnt_finish
);

  typedef enum logic [1:0] {IDLE, LEN, EXT, FIN} state_t;

  typedef struct packed {
    logic [12:0] code;
    logic [3:0]  len;
  } beat_t;

  localparam logic [LEN_W-1:0] L2  = LEN_W'(2);
  localparam logic [LEN_W-1:0] L4  = LEN_W'(4);
  localparam logic [LEN_W-1:0] L5  = LEN_W'(5);
  localparam logic [LEN_W-1:0] L7  = LEN_W'(7);
  localparam logic [LEN_W-1:0] L8  = LEN_W'(8);
  localparam logic [LEN_W-1:0] L15 = LEN_W'(15);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] rem_q, rem_nxt;
  logic             beat_en;
  beat_t            beat;
  logic             accept;
  logic [10:0]      off11;

  // Tokens are only taken between codes, and never after the end marker.
  assign tok_ready = (state == IDLE) && !cnt_finish;
  assign accept    = tok_valid && tok_ready;
  // Offset code field is fixed at 11 bits regardless of OFF_W.
  assign off11     = 11'(tok_off);

  // Next-state and next-beat selection.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    rem_nxt   = rem_q;
    beat_en   = 1'b0;
    beat      = '{code: cnt_output, len: cnt_len};
    case (state)
      IDLE: begin
        if (accept) begin
          case (tok_type)
            2'b00: begin
              beat_en = 1'b1;
              beat    = '{code: {5'b0, tok_lit}, len: 4'd9};
            end
            2'b01: begin
              // Lengths 0/1 are not encodable; treat them as the minimum.
              len_nxt   = (tok_len < L2) ? L2 : tok_len;
              beat_en   = 1'b1;
              state_nxt = LEN;
              // Offset 0 is passed through and collides with the end marker.
              if (off11 < 11'd128)
                beat = '{code: {4'b0, 2'b11, off11[6:0]}, len: 4'd9};
              else
                beat = '{code: {2'b10, off11}, len: 4'd13};
            end
            2'b10: begin
              beat_en   = 1'b1;
              beat      = '{code: {4'b0, 9'b110000000}, len: 4'd9};
              state_nxt = FIN;
            end
            default: ; // reserved type: swallowed without output
          endcase
        end
      end
      LEN: begin
        beat_en   = 1'b1;
        state_nxt = IDLE;
        if (len_q <= L4) begin
          beat = '{code: {11'b0, 2'(len_q - L2)}, len: 4'd2};
        end else if (len_q <= L7) begin
          beat = '{code: {9'b0, 2'b11, 2'(len_q - L5)}, len: 4'd4};
        end else begin
          beat      = '{code: 13'hF, len: 4'd4};
          rem_nxt   = len_q - L8;
          state_nxt = EXT;
        end
      end
      EXT: begin
        beat_en = 1'b1;
        // All-ones nibbles continue the run; any smaller nibble (incl. 0) ends it.
        if (rem_q >= L15) begin
          beat    = '{code: 13'hF, len: 4'd4};
          rem_nxt = rem_q - L15;
        end else begin
          beat      = '{code: {9'b0, rem_q[3:0]}, len: 4'd4};
          state_nxt = IDLE;
        end
      end
      FIN: ; // terminal until reset
      default: state_nxt = IDLE;
    endcase
  end

  // State, length/remainder and registered output beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      len_q             <= '0;
      rem_q             <= '0;
      cnt_output        <= '0;
      cnt_len           <= '0;
      cnt_output_enable <= 1'b0;
      cnt_finish        <= 1'b0;
    end else begin
      state             <= state_nxt;
      len_q             <= len_nxt;
      rem_q             <= rem_nxt;
      cnt_output_enable <= beat_en;
      if (beat_en) begin
        cnt_output <= beat.code;
        cnt_len    <= beat.len;
      end
      // Rises the cycle after the end-marker beat and sticks until reset.
      cnt_finish <= cnt_finish | (state == FIN);
    end
  end

endmodule

// File: tb/tb_encode_token.sv
// tb_encode_token: table of fixed vectors plus random tokens; expected
// beats are queued with their due cycle when a token is driven and
// compared as the encoder emits them.
module tb_encode_token;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic [1:0]  tok_type = '0;
  logic [7:0]  tok_lit = '0;
  logic [10:0] tok_off = '0;
  logic [7:0]  tok_len = '0;
  logic [12:0] cnt_output;
  logic [3:0]  cnt_len;
  logic        cnt_output_enable;
  logic        cnt_finish;

  encode_token #(.OFF_W(11), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_type(tok_type), .tok_lit(tok_lit), .tok_off(tok_off), .tok_len(tok_len),
    .cnt_output(cnt_output), .cnt_len(cnt_len),
    .cnt_output_enable(cnt_output_enable), .cnt_finish(cnt_finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  typedef struct {int code; int len; int at;} exp_t;
  exp_t sb[$];
  int   pc[$];
  int   pl[$];
  int   prev_busy = -1;

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  lit;
    logic [10:0] off;
    logic [7:0]  len;
    int          nb;
    int          c[5];
    int          l[5];
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Beat checker: order, value, length and cycle of every emitted beat.
  always @(negedge clk) begin
    if (rst) begin
      if (cnt_output_enable) begin
        nchk++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL beat_unexpected: got %0h/%0d expected no beat (cycle %0d)",
                   cnt_output, cnt_len, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cnt_output !== 13'(e.code) || cnt_len !== 4'(e.len) || cyc != e.at) begin
            nerr++;
            $display("FAIL beat: got %0h/%0d at %0d expected %0h/%0d at %0d",
                     cnt_output, cnt_len, cyc, e.code, e.len, e.at);
          end
        end
      end else if (sb.size() > 0 && sb[0].at <= cyc) begin
        nchk++;
        nerr++;
        $display("FAIL beat_missing: got no beat expected %0h/%0d at %0d",
                 sb[0].code, sb[0].len, sb[0].at);
        sb.delete(0);
      end
    end
  end

  // Reference encoding of one token into pc/pl.
  function automatic void model(input logic [1:0] t, input logic [7:0] lit,
                                input logic [10:0] off, input logic [7:0] len);
    int L;
    case (t)
      2'd0: begin pc.push_back(int'(lit)); pl.push_back(9); end
      2'd1: begin
        L = (len < 2) ? 2 : int'(len);
        if (off < 128) begin pc.push_back('h180 + int'(off)); pl.push_back(9); end
        else begin pc.push_back('h1000 + int'(off)); pl.push_back(13); end
        if (L <= 4) begin pc.push_back(L - 2); pl.push_back(2); end
        else if (L <= 7) begin pc.push_back('hC + L - 5); pl.push_back(4); end
        else begin
          pc.push_back('hF); pl.push_back(4);
          for (int k = 0; k < (L - 8) / 15; k++) begin pc.push_back('hF); pl.push_back(4); end
          pc.push_back((L - 8) % 15); pl.push_back(4);
        end
      end
      2'd2: begin pc.push_back('h180); pl.push_back(9); end
      default: ;
    endcase
  endfunction

  // Called at a falling edge; drives one token, queues its beats.
  task automatic send(input logic [1:0] t, input logic [7:0] lit,
                      input logic [10:0] off, input logic [7:0] len);
    int w;
    exp_t e;
    w = 0;
    while (!tok_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!tok_ready) begin
      nchk++;
      nerr++;
      $display("FAIL ready_timeout: got tok_ready 0 expected 1 within 100 cycles");
      pc.delete(); pl.delete(); prev_busy = -1;
    end else begin
      if (prev_busy >= 0) chk("ready_latency", w, prev_busy);
      tok_type = t; tok_lit = lit; tok_off = off; tok_len = len; tok_valid = 1'b1;
      for (int k = 0; k < pc.size(); k++) begin
        e.code = pc[k]; e.len = pl[k]; e.at = cyc + 1 + k;
        sb.push_back(e);
      end
      prev_busy = (pc.size() > 0) ? pc.size() - 1 : 0;
      pc.delete(); pl.delete();
      @(negedge clk);
      tok_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_output", cnt_output, 0);
    chk("rst_len", cnt_len, 0);
    chk("rst_enable", cnt_output_enable, 0);
    chk("rst_finish", cnt_finish, 0);
    sb.delete();
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", tok_ready, 1);
    prev_busy = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{2'd0, 8'h41, 11'd0,    8'd0,  1, '{'h041, 0, 0, 0, 0},        '{9, 0, 0, 0, 0}};
    vt[1]  = '{2'd0, 8'h42, 11'd0,    8'd0,  1, '{'h042, 0, 0, 0, 0},        '{9, 0, 0, 0, 0}};
    vt[2]  = '{2'd1, 8'h00, 11'd5,    8'd3,  2, '{'h185, 'h1, 0, 0, 0},      '{9, 2, 0, 0, 0}};
    vt[3]  = '{2'd1, 8'h00, 11'd300,  8'd8,  3, '{'h112C, 'hF, 0, 0, 0},     '{13, 4, 4, 0, 0}};
    vt[4]  = '{2'd1, 8'h00, 11'd1,    8'd40, 5, '{'h181, 'hF, 'hF, 'hF, 2},  '{9, 4, 4, 4, 4}};
    vt[5]  = '{2'd1, 8'h00, 11'd127,  8'd2,  2, '{'h1FF, 0, 0, 0, 0},        '{9, 2, 0, 0, 0}};
    vt[6]  = '{2'd1, 8'h00, 11'd128,  8'd4,  2, '{'h1080, 2, 0, 0, 0},       '{13, 2, 0, 0, 0}};
    vt[7]  = '{2'd1, 8'h00, 11'd2047, 8'd7,  2, '{'h17FF, 'hE, 0, 0, 0},     '{13, 4, 0, 0, 0}};
    vt[8]  = '{2'd1, 8'h00, 11'd10,   8'd23, 4, '{'h18A, 'hF, 'hF, 0, 0},    '{9, 4, 4, 4, 0}};
    vt[9]  = '{2'd1, 8'h00, 11'd64,   8'd0,  2, '{'h1C0, 0, 0, 0, 0},        '{9, 2, 0, 0, 0}};
    vt[10] = '{2'd1, 8'h00, 11'd3,    8'd1,  2, '{'h183, 0, 0, 0, 0},        '{9, 2, 0, 0, 0}};
    vt[11] = '{2'd1, 8'h00, 11'd2,    8'd5,  2, '{'h182, 'hC, 0, 0, 0},      '{9, 4, 0, 0, 0}};
    vt[12] = '{2'd3, 8'h77, 11'd9,    8'd9,  0, '{0, 0, 0, 0, 0},            '{0, 0, 0, 0, 0}};
    vt[13] = '{2'd0, 8'hFF, 11'd0,    8'd0,  1, '{'h0FF, 0, 0, 0, 0},        '{9, 0, 0, 0, 0}};
    vt[14] = '{2'd1, 8'h00, 11'd1000, 8'd22, 3, '{'h13E8, 'hF, 'hE, 0, 0},   '{13, 4, 4, 0, 0}};
    vt[15] = '{2'd1, 8'h00, 11'd0,    8'd9,  3, '{'h180, 'hF, 1, 0, 0},      '{9, 4, 4, 0, 0}};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_output", cnt_output, 0);
    chk("reset_len", cnt_len, 0);
    chk("reset_enable", cnt_output_enable, 0);
    chk("reset_finish", cnt_finish, 0);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", tok_ready, 1);

    // Fixed vectors, back to back
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < vt[i].nb; k++) begin
        pc.push_back(vt[i].c[k]);
        pl.push_back(vt[i].l[k]);
      end
      send(vt[i].t, vt[i].lit, vt[i].off, vt[i].len);
    end

    // Random literals / matches / reserved tokens
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [1:0]  t;
      logic [7:0]  lit;
      logic [10:0] off;
      logic [7:0]  len;
      r   = $urandom_range(0, 9);
      t   = (r < 4) ? 2'd0 : (r < 9) ? 2'd1 : 2'd3;
      lit = 8'($urandom_range(0, 255));
      off = $urandom_range(0, 1) ? 11'($urandom_range(1, 127)) : 11'($urandom_range(128, 2047));
      len = 8'($urandom_range(0, 70));
      model(t, lit, off, len);
      send(t, lit, off, len);
    end
    repeat (25) @(negedge clk);
    chk("drain_random", sb.size(), 0);
    prev_busy = -1;

    // End of stream, then ignored tokens while finished
    model(2'd2, 8'h0, 11'd0, 8'd0);
    send(2'd2, 8'h0, 11'd0, 8'd0);
    chk("finish_not_yet", cnt_finish, 0);
    @(negedge clk);
    chk("finish_set", cnt_finish, 1);
    chk("fin_ready", tok_ready, 0);
    tok_valid = 1'b1; tok_type = 2'd0; tok_lit = 8'h55;
    repeat (4) begin
      @(negedge clk);
      chk("finish_held", cnt_finish, 1);
      chk("fin_ready_held", tok_ready, 0);
    end
    tok_valid = 1'b0;
    do_reset();

    // Reset in the middle of a long match's extension run
    model(2'd1, 8'h0, 11'd1, 8'd200);
    send(2'd1, 8'h0, 11'd1, 8'd200);
    repeat (4) @(negedge clk);
    chk("mid_ext_enable", cnt_output_enable, 1);
    do_reset();
    model(2'd0, 8'h00, 11'd0, 8'd0);
    send(2'd0, 8'h00, 11'd0, 8'd0);
    repeat (20) @(negedge clk);
    chk("drain_final", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
